// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - multi-cycle doubleword data-memory responder with valid/ready handshakes
module data_memory_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_write_i,
   input  logic [63:0] req_addr_i,
   input  logic [63:0] req_wdata_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [63:0] resp_rdata_o,
   output logic        resp_err_o
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [63:0] mem [DEPTH];

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             write_q, write_d;
   logic [63:0]      addr_q, addr_d;
   logic [63:0]      wdata_q, wdata_d;
   logic [63:0]      rdata_q;
   logic             err_q;

   logic             acc_write;
   logic [63:0]      acc_addr;
   logic [63:0]      acc_wdata;
   logic             acc_err;
   logic [IDX_W-1:0] acc_idx;
   logic [63:0]      mem_rd;
   logic             commit;

   // Request seen by the commit edge: live inputs when committing straight from IDLE
   // (zero latency), otherwise the copy latched at acceptance.
   always_comb begin
      acc_write = write_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      if (state_q == IDLE) begin
         acc_write = req_write_i;
         acc_addr  = req_addr_i;
         acc_wdata = req_wdata_i;
      end
      acc_err = (acc_addr[2:0] != 3'd0) || ({3'b000, acc_addr[63:3]} >= 64'(DEPTH));
      acc_idx = acc_addr[IDX_W+2:3];
      mem_rd  = mem[acc_idx];
   end

   // Next-state logic for the IDLE -> WAIT -> RESP handshake sequence.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      write_d = write_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid_i) begin
               write_d = req_write_i;
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               if (LATENCY == 0) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_W'(LATENCY - 1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESP: begin
            if (resp_ready_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      commit = (state_d == RESP) && (state_q != RESP);
   end

   // Control and response registers; reset aborts any in-flight transaction.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         if (commit) begin
            rdata_q <= (acc_write || acc_err) ? 64'd0 : mem_rd;
            err_q   <= acc_err;
         end
      end
   end

   // Array write on the edge entering RESP; contents survive reset.
   always_ff @(posedge clock) begin
      if (commit && !reset && acc_write && !acc_err) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   assign req_ready_o  = (state_q == IDLE);
   assign resp_valid_o = (state_q == RESP);
   assign resp_rdata_o = rdata_q;
   assign resp_err_o   = err_q;

endmodule
